// File: rtl/run_control_pkg.sv
// run_control_pkg: shared types and constants for the debug run-control
// sequencer. Holds the sequencer state encoding and the halt-cause codes
// reported on the run_control `cause` output.
package run_control_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } rc_state_t;

  localparam int unsigned CAUSE_W = 3;

  localparam logic [CAUSE_W-1:0] CAUSE_RESET      = 3'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_HALT_REQ   = 3'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT = 3'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_EBREAK     = 3'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_STEP_DONE  = 3'd4;

  // Priority among simultaneous stop conditions: halt request, then
  // breakpoint, then EBREAK.
  function automatic logic [CAUSE_W-1:0] stop_cause(input logic hreq,
                                                    input logic bp);
    if (hreq)    return CAUSE_HALT_REQ;
    else if (bp) return CAUSE_BREAKPOINT;
    else         return CAUSE_EBREAK;
  endfunction

endpackage

// File: rtl/run_control.sv
// run_control: debug run-control sequencer for the single-cycle RV32 core.
// Gates every architectural update (PC, RegWrite, MemWrite) through cpu_en.
// Ports:
//   clk, reset        core clock; synchronous active-high reset
//   run_req           pulse: start free-running (from HALT)
//   halt_req          level/pulse: stop before the current instruction
//   step_req          pulse: execute step_count instructions (0 means 1)
//   step_count        requested step count, STEP_W bits
//   bp_en, bp_addr    PC breakpoint enable and address
//   pc, is_ebreak     current core PC and EBREAK decode from the core
//   cpu_en            combinational enable for the core's state updates
//   halted            registered: sequencer is in HALT
//   cause             registered: reason for the last halt
//   retired           instructions executed since reset (wraps)
module run_control
  import run_control_pkg::*;
#(
  parameter int unsigned STEP_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_req,
  input  logic                halt_req,
  input  logic                step_req,
  input  logic [STEP_W-1:0]   step_count,
  input  logic                bp_en,
  input  logic [31:0]         bp_addr,
  input  logic [31:0]         pc,
  input  logic                is_ebreak,
  output logic                cpu_en,
  output logic                halted,
  output logic [CAUSE_W-1:0]  cause,
  output logic [31:0]         retired
);

  rc_state_t           state_q, state_d;
  logic [STEP_W-1:0]   steps_left_q, steps_left_d;
  logic                skip_bp_q, skip_bp_d;
  logic [CAUSE_W-1:0]  cause_q, cause_d;
  logic [31:0]         retired_q, retired_d;

  logic bp_hit;
  logic stop;

  // skip_bp masks the breakpoint only until the first executed instruction,
  // so resuming from a breakpoint PC executes that instruction once.
  always_comb begin
    bp_hit = bp_en && (pc == bp_addr) && !skip_bp_q;
    stop   = halt_req || bp_hit || is_ebreak;
    cpu_en = (state_q != ST_HALT) && !stop;
  end

  always_comb begin
    state_d      = state_q;
    steps_left_d = steps_left_q;
    skip_bp_d    = skip_bp_q;
    cause_d      = cause_q;
    retired_d    = retired_q;

    if (cpu_en) begin
      retired_d = retired_q + 32'd1;
      skip_bp_d = 1'b0;
    end

    case (state_q)
      ST_HALT: begin
        if (run_req) begin
          state_d   = ST_RUN;
          skip_bp_d = 1'b1;
        end else if (step_req) begin
          state_d      = ST_STEP;
          steps_left_d = (step_count == '0) ? STEP_W'(1) : step_count;
          skip_bp_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d   = ST_HALT;
          cause_d   = stop_cause(halt_req, bp_hit);
          skip_bp_d = 1'b0;
        end
      end
      ST_STEP: begin
        if (stop) begin
          state_d   = ST_HALT;
          cause_d   = stop_cause(halt_req, bp_hit);
          skip_bp_d = 1'b0;
        end else if (steps_left_q == STEP_W'(1)) begin
          state_d   = ST_HALT;
          cause_d   = CAUSE_STEP_DONE;
          skip_bp_d = 1'b0;
        end else begin
          steps_left_d = steps_left_q - STEP_W'(1);
        end
      end
      default: begin
        state_d   = ST_HALT;
        skip_bp_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HALT;
      steps_left_q <= '0;
      skip_bp_q    <= 1'b0;
      cause_q      <= CAUSE_RESET;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      steps_left_q <= steps_left_d;
      skip_bp_q    <= skip_bp_d;
      cause_q      <= cause_d;
      retired_q    <= retired_d;
    end
  end

  always_comb begin
    halted  = (state_q == ST_HALT);
    cause   = cause_q;
    retired = retired_q;
  end

endmodule

// File: tb/tb_run_control.sv
// tb_run_control: directed-vector bench for run_control. The stimulus
// process drives inputs just after each rising edge and queues the outputs
// expected in that cycle; a monitor samples the DUT on the falling edge and
// checks against the queue.
module tb_run_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_req, halt_req, step_req;
  logic [7:0]  step_count;
  logic        bp_en;
  logic [31:0] bp_addr, pc;
  logic        is_ebreak;
  logic        cpu_en, halted;
  logic [2:0]  cause;
  logic [31:0] retired;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string       nm;
    logic        en;
    logic        hl;
    logic [2:0]  ca;
    logic [31:0] rt;
  } exp_t;

  exp_t exp_q[$];

  run_control #(.STEP_W(8)) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .step_count(step_count), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .is_ebreak(is_ebreak), .cpu_en(cpu_en),
    .halted(halted), .cause(cause), .retired(retired)
  );

  always #5 clk = ~clk;

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total += 4;
      if (cpu_en !== e.en) begin
        bad++;
        $display("FAIL %s cpu_en: got %0b want %0b", e.nm, cpu_en, e.en);
      end
      if (halted !== e.hl) begin
        bad++;
        $display("FAIL %s halted: got %0b want %0b", e.nm, halted, e.hl);
      end
      if (cause !== e.ca) begin
        bad++;
        $display("FAIL %s cause: got %0d want %0d", e.nm, cause, e.ca);
      end
      if (retired !== e.rt) begin
        bad++;
        $display("FAIL %s retired: got %h want %h", e.nm, retired, e.rt);
      end
    end
  end

  // Queue the outputs expected in the current cycle, then advance one edge.
  task automatic cyc(input string nm, input logic en, input logic hl,
                     input logic [2:0] ca, input logic [31:0] rt);
    exp_t e;
    e.nm = nm; e.en = en; e.hl = hl; e.ca = ca; e.rt = rt;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; run_req = 0; halt_req = 0; step_req = 0; step_count = '0;
    bp_en = 0; bp_addr = '0; pc = '0; is_ebreak = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state held while idle.
    for (int i = 0; i < 5; i++) cyc("idle", 0, 1, 0, 0);

    // Step of 3 from PC 0.
    step_req = 1; step_count = 8'd3; pc = 0;
    cyc("step3_req", 0, 1, 0, 0);
    step_req = 0;
    pc = 0;  cyc("step3_a", 1, 0, 0, 0);
    pc = 4;  cyc("step3_b", 1, 0, 0, 1);
    pc = 8;  cyc("step3_c", 1, 0, 0, 2);
    pc = 12; cyc("step3_done", 0, 1, 4, 3);
    cyc("step3_hold", 0, 1, 4, 3);

    // Step count 0 behaves as 1.
    step_req = 1; step_count = 8'd0;
    cyc("step0_req", 0, 1, 4, 3);
    step_req = 0;
    cyc("step0_a", 1, 0, 4, 3);
    pc = 16; cyc("step0_done", 0, 1, 4, 4);

    // Breakpoint at 0x10, run from 0.
    bp_en = 1; bp_addr = 32'h10; pc = 0; run_req = 1;
    cyc("bp_run", 0, 1, 4, 4);
    run_req = 0;
    pc = 0;  cyc("bp_r0", 1, 0, 4, 4);
    pc = 4;  cyc("bp_r1", 1, 0, 4, 5);
    pc = 8;  cyc("bp_r2", 1, 0, 4, 6);
    pc = 12; cyc("bp_r3", 1, 0, 4, 7);
    pc = 16; cyc("bp_hit", 0, 0, 4, 8);
    cyc("bp_halted", 0, 1, 2, 8);

    // Resume from the breakpoint PC: it executes once, then runs on.
    run_req = 1; cyc("bp_resume", 0, 1, 2, 8);
    run_req = 0;
    pc = 16; cyc("bp_skip", 1, 0, 2, 8);
    pc = 20; cyc("bp_on1", 1, 0, 2, 9);
    pc = 24; cyc("bp_on2", 1, 0, 2, 10);

    // halt_req, breakpoint and EBREAK together: halt request wins.
    pc = 16; halt_req = 1; is_ebreak = 1;
    cyc("prio_stop", 0, 0, 2, 11);
    halt_req = 0; is_ebreak = 0; bp_en = 0;
    cyc("prio_cause", 0, 1, 1, 11);

    // EBREAK at 0x8, then resume on it.
    pc = 0; run_req = 1; cyc("eb_run", 0, 1, 1, 11);
    run_req = 0;
    pc = 0; cyc("eb_r0", 1, 0, 1, 11);
    pc = 4; cyc("eb_r1", 1, 0, 1, 12);
    pc = 8; is_ebreak = 1; cyc("eb_stop", 0, 0, 1, 13);
    cyc("eb_halted", 0, 1, 3, 13);
    run_req = 1; cyc("eb_resume", 0, 1, 3, 13);
    run_req = 0; cyc("eb_rehalt", 0, 0, 3, 13);
    cyc("eb_rehalted", 0, 1, 3, 13);
    is_ebreak = 0;

    // run_req and step_req together: RUN, so no step-done after 2.
    pc = 0; run_req = 1; step_req = 1; step_count = 8'd2;
    cyc("both_req", 0, 1, 3, 13);
    run_req = 0; step_req = 0;
    pc = 0; cyc("both_r0", 1, 0, 3, 13);
    pc = 4; cyc("both_r1", 1, 0, 3, 14);
    pc = 8; cyc("both_r2", 1, 0, 3, 15);
    pc = 12; halt_req = 1; cyc("both_halt", 0, 0, 3, 16);
    halt_req = 0; cyc("both_halted", 0, 1, 1, 16);

    // Retired counter wrap: preload all-ones, retire once.
    force dut.retired_d = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.retired_d;
    pc = 0; run_req = 1; cyc("wrap_run", 0, 1, 1, 32'hFFFF_FFFF);
    run_req = 0; cyc("wrap_r0", 1, 0, 1, 32'hFFFF_FFFF);
    pc = 4; halt_req = 1; cyc("wrap_zero", 0, 0, 1, 0);
    halt_req = 0; cyc("wrap_halted", 0, 1, 1, 0);

    // Reset while running.
    pc = 0; run_req = 1; cyc("rst_run", 0, 1, 1, 0);
    run_req = 0; cyc("rst_r0", 1, 0, 1, 0);
    pc = 4; reset = 1; cyc("rst_assert", 1, 0, 1, 1);
    reset = 0; cyc("rst_after", 0, 1, 0, 0);
    cyc("rst_idle", 0, 1, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/run_control.md
# run_control

Debug run-control sequencer for the single-cycle RV32 core. It gates all architectural state updates (PC, register-file write, data-memory write) through one enable, `cpu_en`. The debugger can run, halt and single- or multi-step the core through it. Execution stops on a PC breakpoint or on an EBREAK instruction, and every retired instruction is counted. The block sits between the board-level debug inputs and the core's PC/RegWrite/MemWrite qualifiers.

## Interface
Parameters:
- `STEP_W`, default 8: width of the step-count request.

Ports:
- `clk`, in, 1: core clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `run_req`, in, 1: one-cycle pulse; start free-running.
- `halt_req`, in, 1: level or pulse; stop before the current instruction.
- `step_req`, in, 1: one-cycle pulse; execute `step_count` instructions.
- `step_count`, in, `STEP_W`: number of instructions to step; 0 is treated as 1.
- `bp_en`, in, 1: breakpoint enable.
- `bp_addr`, in, 32: breakpoint PC.
- `pc`, in, 32: current core PC.
- `is_ebreak`, in, 1: current instruction is EBREAK (decoded in the core).
- `cpu_en`, out, 1: qualifies the PC register, RegWrite and MemWrite.
- `halted`, out, 1: state is HALT.
- `cause`, out, 3: reason for the last halt.
- `retired`, out, 32: instructions executed since reset.

## Operation
- States: HALT, RUN, STEP.
- Reset values:
  - state = HALT, `cause` = RESET, `retired` = 0.
  - `steps_left` = 0, `skip_bp` = 0.
  - `halted` = 1, `cpu_en` = 0.
- Cause encoding: RESET = 0, HALT_REQ = 1, BREAKPOINT = 2, EBREAK = 3, STEP_DONE = 4. Values 5–7 are unused.
- `bp_hit` = `bp_en` & (`pc` == `bp_addr`) & !`skip_bp`.
- `stop` = `halt_req` | `bp_hit` | `is_ebreak`.
- `cpu_en` = (state is RUN or STEP) & !`stop`. It is combinational; a stopping instruction is never executed.
- HALT transitions:
  - `run_req` → RUN, with `skip_bp` ← 1.
  - Otherwise `step_req` → STEP, with `steps_left` ← max(`step_count`, 1) and `skip_bp` ← 1.
  - `run_req` wins if both requests arrive together.
  - `halt_req` is ignored while in HALT.
- RUN:
  - If `stop`: → HALT.
  - Otherwise stay in RUN.
- STEP:
  - If `stop`: → HALT.
  - Else if `steps_left` == 1: → HALT with `cause` = STEP_DONE.
  - Otherwise `steps_left` decrements by 1.
- Stop-cause priority when several stop conditions are true: HALT_REQ > BREAKPOINT > EBREAK. `cause` is latched on the HALT entry edge.
- `skip_bp` clears on the first cycle in which `cpu_en` = 1, and on any entry to HALT. This lets the core resume from a breakpoint PC. It does not suppress EBREAK: resuming on an EBREAK re-halts immediately with zero instructions retired.
- `run_req` / `step_req` seen in RUN or STEP are ignored.
- `retired` increments by 1 on every edge where `cpu_en` = 1 and wraps modulo 2^32.
- `reset` mid-run or mid-step forces all reset values on the next edge. Reset overrides every request.

## Timing
- Requests are sampled at the rising edge.
- If `run_req` is sampled in HALT at edge k, the state is RUN after edge k. `cpu_en` can first be high in cycle k+1, and the first instruction retires at edge k+1.
- A step of N with no stops gives exactly N cycles of `cpu_en` = 1. `halted` rises at the edge that retires the Nth instruction.
- A stop condition in cycle j gives `cpu_en` = 0 in cycle j (zero latency) and `halted` = 1 from edge j onward.
- `halted` and `cause` are registered. `cpu_en` depends combinationally on `pc`, `is_ebreak`, `halt_req` and state; the core must not feed `cpu_en` back into `pc` combinationally.

## Structure
- Package `run_control_pkg` holds:
  - the state encoding (HALT, RUN, STEP, 2 bits);
  - the `cause` constants CAUSE_RESET … CAUSE_STEP_DONE;
  - the cause width, 3.
- No sub-module. Single always block for state, `steps_left`, `skip_bp`, `cause` and `retired`; separate combinational logic for `stop` and `cpu_en`.

## Test plan
- Reset, then idle 5 cycles → `halted` = 1, `cause` = 0, `cpu_en` = 0, `retired` = 0. Assert `reset` during RUN → HALT and `retired` = 0 on the next edge.
- `step_req` with `step_count` = 3, PC advancing by 4 from 0 → `cpu_en` high for exactly 3 cycles, `retired` = 3, `cause` = 4. Repeat with `step_count` = 0 → exactly 1 retire.
- `bp_en` = 1, `bp_addr` = 0x10, `run_req` from PC 0 → 4 retires, halt at PC 0x10 with `cause` = 2 and `cpu_en` low at PC 0x10. A further `run_req` → instruction at 0x10 retires (skip works) and the core runs on.
- `run_req`, then `halt_req` for 1 cycle while `bp_hit` and `is_ebreak` are also true → `cause` = 1 and the instruction is not retired.
- `is_ebreak` held at PC 0x8 → halt with `cause` = 3. A further `run_req` → re-halts the next cycle with `retired` unchanged.
- Preload `retired` = 0xFFFFFFFF via forced run, retire once → `retired` = 0. Simultaneous `run_req` and `step_req` in HALT → RUN; `steps_left` not loaded.
